regfile_copy_engine: RTL and testbench
======================================

Name: regfile_copy_engine

Overview:
- Bus master for the team's 256x8 register file.
- Drives the file's read port (R_Addr/R_en, R_Data returned combinationally in the same cycle) and write port (W_Addr/W_en/W_Data).
- Performs block copy (src range to dst range, overlap-safe) or block fill (constant to dst range), with Busy/Done status and a running byte checksum.

Parameters:
ADDR_W, 8, address width; register file depth is 2**ADDR_W
DATA_W, 8, data width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset; asynchronous, active-low
Start  in  1  begin operation; sampled only in IDLE
Fill  in  1  mode at Start: 0 = copy, 1 = fill
Src_Addr  in  ADDR_W  copy source base
Dst_Addr  in  ADDR_W  destination base
Len  in  ADDR_W+1  byte count; 0 = no-op, values >256 clamp to 256
Fill_Data  in  DATA_W  fill value
Abort  in  1  terminate early
R_Addr  out  ADDR_W  read address to register file
R_en  out  1  read enable
R_Data  in  DATA_W  read data from register file
W_Addr  out  ADDR_W  write address
W_en  out  1  write enable
W_Data  out  DATA_W  write data
Busy  out  1  high in READ/WRITE/FILL
Done  out  1  one-cycle pulse at end of operation
Aborted  out  1  high with Done if ended by Abort; held until next Start
Sum  out  DATA_W  mod-256 sum of bytes written in current/last operation

Behaviour:
- Reset (Rst=0, async): state IDLE; all outputs 0, including Sum and Aborted; internal pointers, count and data register 0.
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE, Start=1:
  - Latch Src_Addr, Dst_Addr, Fill_Data and clamped Len; clear Sum and Aborted.
  - Len=0 -> DONE. Fill=1 -> FILL. Otherwise -> READ.
- Copy direction, decided at Start:
  - d = (Dst_Addr - Src_Addr) mod 256.
  - If 0 < d < Len: descending. Pointers start at Src+Len-1 and Dst+Len-1 (mod 256) and decrement.
  - Otherwise: ascending from the bases, incrementing.
- Address arithmetic wraps mod 256; no error on wrap.
- READ (1 cycle):
  - R_en=1, R_Addr=src pointer.
  - R_Data is captured into the data register at the cycle-ending edge; then -> WRITE.
- WRITE (1 cycle):
  - W_en=1, W_Addr=dst pointer, W_Data=data register.
  - At the edge: Sum += data, advance both pointers, decrement remaining count.
  - Remaining count becomes 0 -> DONE; else -> READ.
- FILL (1 cycle per byte): W_en=1, W_Data=Fill_Data, W_Addr=dst pointer (always ascending). Same count, Sum and pointer update as WRITE.
- Timing: copy of N bytes = 2N cycles of Busy; fill = N cycles.
- R_en=0 outside READ; W_en=0 outside WRITE/FILL. R_Addr, W_Addr and W_Data hold their last values when not enabled.
- DONE (1 cycle): Done=1, Busy=0; -> IDLE. Start during DONE is ignored.
- Start while Busy is ignored. Fill_Data and the address inputs are not re-sampled mid-operation.
- Abort:
  - Sampled in READ/WRITE/FILL; the current cycle's access still completes.
  - Next state is DONE with Aborted=1.
  - Abort in READ: the pending byte is not written and Sum is unchanged.
  - Abort in IDLE or DONE has no effect.
- Start and Abort high together in IDLE: Start wins; Abort is ignored that cycle.
- Reset asserted mid-operation: immediate return to IDLE, enables drop to 0 asynchronously, no Done pulse.

Test Plan:
- Ascending copy. File preloaded with mem[i]=i. Src=0x10, Dst=0x80, Len=4, Fill=0 -> 8 Busy cycles; writes 0x80..0x83 = 0x10..0x13; Done one cycle later; Sum=0x46; Aborted=0.
- Overlapping copy. Src=0x20, Dst=0x22, Len=4 -> descending, write order 0x25,0x24,0x23,0x22; final mem[0x22..0x25] = 0x20..0x23 (no corruption).
- Wrap-around copy. Src=0xFE, Dst=0x00, Len=3, mem[0xFE]=0x0C, mem[0xFF]=0x32, mem[0x00]=0x19 -> d=2<3, so descending; writes 0x02=0x19, 0x01=0x32, 0x00=0x0C; Sum=0x57.
- Fill plus zero length. Fill=1, Dst=0xF0, Len=0x100, Fill_Data=0xFA -> 256 Busy cycles; all bytes = 0xFA; Sum=0x00. Then Len=0 -> Done in the cycle after Start, no W_en.
- Abort. Copy Len=10, Abort pulsed in the 3rd READ -> exactly 2 bytes written; Done with Aborted=1; Sum = sum of those 2 bytes. A Start issued while Busy in an earlier run is ignored.
- Reset mid-copy. Rst=0 during WRITE -> W_en=0 immediately; all outputs 0; no Done pulse; a following Start runs a full copy normally.

Source files
------------

// File: rtl/regfile_copy_engine.sv
// Block copy / block fill master for a 256x8 register file with a combinational read port.
// Copies run read-then-write per byte, and the walk direction is chosen at Start so that overlapping ranges copy correctly.
module regfile_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Fill,
    input  logic [ADDR_W-1:0] Src_Addr,
    input  logic [ADDR_W-1:0] Dst_Addr,
    input  logic [ADDR_W:0]   Len,
    input  logic [DATA_W-1:0] Fill_Data,
    input  logic              Abort,
    output logic [ADDR_W-1:0] R_Addr,
    output logic              R_en,
    input  logic [DATA_W-1:0] R_Data,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              W_en,
    output logic [DATA_W-1:0] W_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Aborted,
    output logic [DATA_W-1:0] Sum
);

    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FILL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_srcPtr;
    logic [ADDR_W-1:0] r_dstPtr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_fillData;
    logic              r_descend;
    logic [DATA_W-1:0] r_sum;
    logic              r_aborted;
    logic [ADDR_W-1:0] r_rAddrHold;
    logic [ADDR_W-1:0] r_wAddrHold;
    logic [DATA_W-1:0] r_wDataHold;

    logic [ADDR_W:0]   w_lenClamp;
    logic [ADDR_W-1:0] w_dist;
    logic [ADDR_W-1:0] w_lastOfs;
    logic              w_descend;
    logic              w_lastByte;
    logic [DATA_W-1:0] w_wrData;

    // Overlap-safe direction: walk downwards only when the destination starts inside the source range.
    always_comb begin
        w_lenClamp = (Len > MAX_LEN) ? MAX_LEN : Len;
        w_dist     = Dst_Addr - Src_Addr;
        w_lastOfs  = w_lenClamp[ADDR_W-1:0] - ONE_A;
        w_descend  = !Fill && (w_dist != '0) && ({1'b0, w_dist} < w_lenClamp);
        w_lastByte = (r_count == ONE_C);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (w_lenClamp == '0) begin
                        w_next = S_DONE;
                    end else if (Fill) begin
                        w_next = S_FILL;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ:  w_next = Abort ? S_DONE : S_WRITE;
            S_WRITE: w_next = (Abort || w_lastByte) ? S_DONE : S_READ;
            S_FILL:  w_next = (Abort || w_lastByte) ? S_DONE : S_FILL;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs present the live pointer while enabled and the last driven value otherwise.
    always_comb begin
        R_en     = (r_state == S_READ);
        W_en     = (r_state == S_WRITE) || (r_state == S_FILL);
        Busy     = R_en || W_en;
        Done     = (r_state == S_DONE);
        Aborted  = r_aborted;
        Sum      = r_sum;
        w_wrData = (r_state == S_FILL) ? r_fillData : r_data;
        R_Addr   = R_en ? r_srcPtr : r_rAddrHold;
        W_Addr   = W_en ? r_dstPtr : r_wAddrHold;
        W_Data   = W_en ? w_wrData : r_wDataHold;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_srcPtr    <= '0;
            r_dstPtr    <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_fillData  <= '0;
            r_descend   <= 1'b0;
            r_sum       <= '0;
            r_aborted   <= 1'b0;
            r_rAddrHold <= '0;
            r_wAddrHold <= '0;
            r_wDataHold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_srcPtr   <= w_descend ? (Src_Addr + w_lastOfs) : Src_Addr;
                        r_dstPtr   <= w_descend ? (Dst_Addr + w_lastOfs) : Dst_Addr;
                        r_count    <= w_lenClamp;
                        r_fillData <= Fill_Data;
                        r_descend  <= w_descend;
                        r_sum      <= '0;
                        r_aborted  <= 1'b0;
                    end
                end
                S_READ: begin
                    r_data      <= R_Data;
                    r_rAddrHold <= r_srcPtr;
                    if (Abort) begin
                        r_aborted <= 1'b1;
                    end
                end
                S_WRITE, S_FILL: begin
                    r_sum       <= r_sum + w_wrData;
                    r_wAddrHold <= r_dstPtr;
                    r_wDataHold <= w_wrData;
                    r_srcPtr    <= r_descend ? (r_srcPtr - ONE_A) : (r_srcPtr + ONE_A);
                    r_dstPtr    <= r_descend ? (r_dstPtr - ONE_A) : (r_dstPtr + ONE_A);
                    r_count     <= r_count - ONE_C;
                    if (Abort) begin
                        r_aborted <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_copy_engine.sv
// Bench for regfile_copy_engine: owns the 256x8 register file and keeps a snapshot-based reference model
// that predicts every write, the final memory image, Sum/Aborted at Done, and the Busy duration.
module tb_regfile_copy_engine;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic       Fill;
    logic [7:0] Src_Addr;
    logic [7:0] Dst_Addr;
    logic [8:0] Len;
    logic [7:0] Fill_Data;
    logic       Abort;
    logic [7:0] R_Addr;
    logic       R_en;
    logic [7:0] R_Data;
    logic [7:0] W_Addr;
    logic       W_en;
    logic [7:0] W_Data;
    logic       Busy;
    logic       Done;
    logic       Aborted;
    logic [7:0] Sum;

    logic [7:0] mem[256];
    logic [7:0] refMem[256];

    logic [7:0] expAddr[$];
    logic [7:0] expData[$];
    logic [7:0] pendAddr[$];
    logic [7:0] pendData[$];
    logic [7:0] wrLog[$];
    logic [7:0] expSum;
    logic       expAborted;

    int vectors;
    int miscompares;

    regfile_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Fill(Fill),
        .Src_Addr(Src_Addr), .Dst_Addr(Dst_Addr), .Len(Len), .Fill_Data(Fill_Data),
        .Abort(Abort), .R_Addr(R_Addr), .R_en(R_en), .R_Data(R_Data),
        .W_Addr(W_Addr), .W_en(W_en), .W_Data(W_Data), .Busy(Busy),
        .Done(Done), .Aborted(Aborted), .Sum(Sum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign R_Data = mem[R_Addr];

    // The register file: writes land on the rising edge; reads and writes never share a cycle.
    always @(posedge Clk) begin
        if (W_en) mem[W_Addr] = W_Data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every cycle: each write must be the next one the model predicted, and Done must carry the predicted status.
    always @(negedge Clk) begin
        if (Rst) begin
            if (W_en) begin
                wrLog.push_back(W_Addr);
                vectors++;
                if (expAddr.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected no write", W_Addr, W_Data);
                end else begin
                    logic [7:0] a;
                    logic [7:0] d;
                    a = expAddr.pop_front();
                    d = expData.pop_front();
                    if (W_Addr !== a || W_Data !== d) begin
                        miscompares++;
                        $display("[TB] FAIL writeBeat: got 0x%0h<=0x%0h, expected 0x%0h<=0x%0h", W_Addr, W_Data, a, d);
                    end
                end
            end
            if (R_en && W_en) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL busExclusive: got R_en=1 W_en=1, expected at most one");
            end
            if (Done) begin
                checkOutput("doneSum", Sum, expSum);
                checkOutput("doneAborted", Aborted, expAborted);
                checkOutput("doneWritesLeft", expAddr.size(), 0);
            end
        end
    end

    task automatic preloadIdentity();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i);
            refMem[i] = 8'(i);
        end
    endtask

    task automatic setByte(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        refMem[a] = d;
    endtask

    // Reference model: bytes come from a snapshot of the file taken at Start, which is exactly what an
    // overlap-safe copy must produce; the walk order follows the destination-inside-source rule.
    task automatic modelOp(input bit fill, input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                           input logic [7:0] fd, input int abortK, output int busyExp);
        logic [7:0] snap[256];
        int n;
        int d;
        int nBytes;
        int off;
        bit desc;
        bit ab;
        for (int i = 0; i < 256; i++) snap[i] = refMem[i];
        n = (len > 9'd256) ? 256 : int'(len);
        d = (int'(dst) - int'(src) + 256) % 256;
        desc = !fill && d != 0 && d < n;
        ab = abortK > 0 && abortK <= n;
        nBytes = ab ? abortK - 1 : n;
        expAddr.delete();
        expData.delete();
        pendAddr.delete();
        pendData.delete();
        expSum = 8'h00;
        expAborted = ab;
        for (int k = 0; k < nBytes; k++) begin
            logic [7:0] a;
            logic [7:0] v;
            off = desc ? n - 1 - k : k;
            a = 8'((int'(dst) + off) % 256);
            v = fill ? fd : snap[(int'(src) + off) % 256];
            expAddr.push_back(a);
            expData.push_back(v);
            pendAddr.push_back(a);
            pendData.push_back(v);
            expSum = expSum + v;
        end
        busyExp = fill ? nBytes : 2 * nBytes + (ab ? 1 : 0);
    endtask

    task automatic applyStimulus(input bit fill, input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                                 input logic [7:0] fd, input int abortK, input int startBusyAt, input bit resetInWrite,
                                 output int busyOut);
        int busyExp;
        int busy;
        int reads;
        int bad;
        bit doneSeen;
        modelOp(fill, src, dst, len, fd, abortK, busyExp);
        wrLog.delete();
        @(posedge Clk); #1;
        Fill = fill; Src_Addr = src; Dst_Addr = dst; Len = len; Fill_Data = fd; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Fill = 1'b0; Src_Addr = 8'h5A; Dst_Addr = 8'hA5; Len = 9'd77; Fill_Data = 8'h3C;
        busy = 0;
        reads = 0;
        doneSeen = 1'b0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (Done) begin
                doneSeen = 1'b1;
                break;
            end
            if (Busy) busy++;
            if (R_en) reads++;
            Abort = (abortK > 0) && R_en && (reads == abortK);
            Start = (startBusyAt > 0) && (busy == startBusyAt);
            Fill = Start;
            if (resetInWrite && W_en) begin
                Rst = 1'b0;
                #1;
                checkOutput("resetOutputs",
                            {W_en, R_en, Busy, Done, Aborted, Sum, R_Addr, W_Addr, W_Data}, 0);
                expAddr.delete();
                expData.delete();
                repeat (2) begin
                    @(posedge Clk); #1;
                    checkOutput("resetNoDone", Done, 1'b0);
                end
                Rst = 1'b1;
                Abort = 1'b0; Start = 1'b0; Fill = 1'b0;
                busyOut = busy;
                return;
            end
            @(posedge Clk); #1;
        end
        Abort = 1'b0;
        Start = 1'b0;
        Fill = 1'b0;
        busyOut = busy;
        if (!doneSeen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL doneTimeout: got no Done within 700 cycles, expected Done");
            return;
        end
        checkOutput("busyCycles", busy, busyExp);
        @(posedge Clk); #1;
        checkOutput("donePulse", Done, 1'b0);
        for (int i = 0; i < pendAddr.size(); i++) refMem[pendAddr[i]] = pendData[i];
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) bad++;
        checkOutput("memImage", bad, 0);
    endtask

    initial begin
        int busy;
        int bad;
        vectors = 0;
        miscompares = 0;
        Rst = 1'b0; Start = 1'b0; Fill = 1'b0; Src_Addr = 8'h00; Dst_Addr = 8'h00;
        Len = 9'd0; Fill_Data = 8'h00; Abort = 1'b0;
        preloadIdentity();
        #1;
        checkOutput("resetState", {R_en, W_en, Busy, Done, Aborted, Sum, R_Addr, W_Addr, W_Data}, 0);
        #20;
        @(posedge Clk); #1;
        Rst = 1'b1;
        $display("[TB] reset released");

        applyStimulus(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, 0, 0, 1'b0, busy);
        checkOutput("ascBusy", busy, 8);
        checkOutput("ascSum", Sum, 8'h46);
        checkOutput("ascAborted", Aborted, 1'b0);
        checkOutput("ascBytes", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'h10111213);

        applyStimulus(1'b0, 8'h20, 8'h22, 9'd4, 8'h00, 0, 0, 1'b0, busy);
        checkOutput("ovlOrder", {wrLog[0], wrLog[1], wrLog[2], wrLog[3]}, 32'h25242322);
        checkOutput("ovlBytes", {mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25]}, 32'h20212223);

        setByte(8'hFE, 8'h0C);
        setByte(8'hFF, 8'h32);
        setByte(8'h00, 8'h19);
        applyStimulus(1'b0, 8'hFE, 8'h00, 9'd3, 8'h00, 0, 0, 1'b0, busy);
        checkOutput("wrapOrder", {wrLog[0], wrLog[1], wrLog[2]}, 24'h020100);
        checkOutput("wrapBytes", {mem[8'h00], mem[8'h01], mem[8'h02]}, 24'h0C3219);
        checkOutput("wrapSum", Sum, 8'h57);

        applyStimulus(1'b1, 8'h00, 8'hF0, 9'h100, 8'hFA, 0, 0, 1'b0, busy);
        checkOutput("fillBusy", busy, 256);
        checkOutput("fillSum", Sum, 8'h00);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 8'hFA) bad++;
        checkOutput("fillAllFA", bad, 0);

        applyStimulus(1'b1, 8'h00, 8'h10, 9'h1FF, 8'h07, 0, 0, 1'b0, busy);
        checkOutput("clampBusy", busy, 256);
        checkOutput("clampSum", Sum, 8'h00);

        applyStimulus(1'b0, 8'h40, 8'h50, 9'd0, 8'h00, 0, 0, 1'b0, busy);
        checkOutput("zeroLenBusy", busy, 0);
        checkOutput("zeroLenWrites", wrLog.size(), 0);

        preloadIdentity();
        applyStimulus(1'b0, 8'h40, 8'h60, 9'd10, 8'h00, 3, 2, 1'b0, busy);
        checkOutput("abortBusy", busy, 5);
        checkOutput("abortSum", Sum, 8'h81);
        checkOutput("abortBytes", {mem[8'h60], mem[8'h61], mem[8'h62]}, 24'h404162);
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("abortHeld", Aborted, 1'b1);

        applyStimulus(1'b0, 8'h30, 8'h90, 9'd6, 8'h00, 0, 0, 1'b1, busy);
        applyStimulus(1'b0, 8'h30, 8'h90, 9'd6, 8'h00, 0, 0, 1'b0, busy);
        checkOutput("postResetBusy", busy, 12);
        checkOutput("postResetSum", Sum, 8'h2F);
        checkOutput("postResetAborted", Aborted, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
